ram_stream_reader: RTL and testbench

- Read-side engine for the 64x16 dual-port RAM with synchronous read.
- Drives the RAM's read-only port address and captures its registered read data.
- Emits a programmed block of words as a valid/ready stream with a last marker.
- Sits between the RAM and downstream consumers; a writer owns the RAM's write port independently.

---
 rtl/ram_stream_pkg.sv | 15 +
 rtl/ram_stream_reader_if.sv | 27 ++
 rtl/ram_stream_reader_fifo2.sv | 80 ++++++++
 rtl/ram_stream_reader.sv | 170 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader block:
// FSM state encoding, FIFO depth and default RAM geometry.
package ram_stream_pkg;

    localparam int DEF_AW     = 6;
    localparam int DEF_DW     = 16;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready stream carrying one RAM word per beat plus an end-of-block marker.
interface ram_stream_reader_if
    import ram_stream_pkg::*;
#(
    parameter int DW = DEF_DW
);

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/ram_stream_reader_fifo2.sv
// Two-entry FIFO holding captured RAM words together with their last flag.
// Push and pop in the same cycle leave the occupancy unchanged; a push while
// full is only honoured when a pop frees a slot in the same cycle.
module ram_stream_fifo2
    import ram_stream_pkg::*;
#(
    parameter int W = DEF_DW + 1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]          mem_reg [FIFO_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;
    logic                  do_push;
    logic                  do_pop;
    logic [FIFO_DEPTH-1:0] wr_en;

    assign full    = (count_reg == 2'(FIFO_DEPTH));
    assign empty   = (count_reg == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // One write enable per storage slot, selected by the write pointer.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push & (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    // Storage slots; cleared on reset so the head reads as zero when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side engine for a synchronous-read dual-port RAM. On start it reads
// len words beginning at base (address wraps modulo 2^AW) and streams them
// out over a valid/ready interface, tagging the final word with last.
// The first read is issued in the start cycle itself so the first beat is
// presented two cycles later; a two-entry FIFO sustains one word per cycle.
// Optional feature: define RAM_STREAM_READER_CNT_EN to add the beat_cnt port.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
`ifdef RAM_STREAM_READER_CNT_EN
    output logic [AW:0]   beat_cnt,
`endif
    ram_stream_reader_if.master m
);

    state_t        state_reg, state_next;
    logic [AW-1:0] base_reg, base_next;
    logic [AW:0]   len_reg, len_next;
    logic [AW:0]   issued_reg, issued_next;
    logic          inflight_reg, inflight_next;
    logic          inflight_last_reg, inflight_last_next;
    logic          done_zero_reg, done_zero_next;

    logic          fire;
    logic          final_fire;
    logic [2:0]    slots_used;
    logic [AW-1:0] issue_base;
    logic [AW:0]   issue_idx;

    logic [DW:0]   fifo_head;
    logic [1:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    assign fire = m.valid & m.ready;

    // Slots that will be occupied at the end of this cycle: stored words plus
    // the word arriving from the RAM, minus the one leaving downstream. A new
    // read may only issue when its data is guaranteed a slot next cycle.
    assign slots_used = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, fire};

    // Next-state logic: start handling, read issue and end-of-block detection.
    always_comb begin
        state_next         = state_reg;
        base_next          = base_reg;
        len_next           = len_reg;
        issued_next        = issued_reg;
        inflight_next      = 1'b0;
        inflight_last_next = 1'b0;
        done_zero_next     = 1'b0;
        final_fire         = 1'b0;
        issue_base         = base_reg;
        issue_idx          = issued_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_zero_next = 1'b1;
                    end else begin
                        // The FIFO is empty and nothing is in flight here,
                        // so the first read goes out straight away.
                        base_next          = base;
                        len_next           = len;
                        issue_base         = base;
                        issue_idx          = '0;
                        issued_next        = (AW+1)'(1);
                        inflight_next      = 1'b1;
                        inflight_last_next = (len == (AW+1)'(1));
                        state_next         = RUN;
                    end
                end
            end
            RUN: begin
                if ((issued_reg < len_reg) && (slots_used < 3'd2) && (~fifo_full | fire)) begin
                    issued_next        = issued_reg + (AW+1)'(1);
                    inflight_next      = 1'b1;
                    inflight_last_next = (issued_reg == len_reg - (AW+1)'(1));
                end
                if (issued_next == len_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fire && fifo_head[DW]) begin
                    final_fire = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched request and read-pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            base_reg          <= '0;
            len_reg           <= '0;
            issued_reg        <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_zero_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            base_reg          <= base_next;
            len_reg           <= len_next;
            issued_reg        <= issued_next;
            inflight_reg      <= inflight_next;
            inflight_last_reg <= inflight_last_next;
            done_zero_reg     <= done_zero_next;
        end
    end

    assign ram_addr = issue_base + issue_idx[AW-1:0];

    ram_stream_fifo2 #(
        .W (DW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data ({inflight_last_reg, ram_rdata}),
        .pop       (fire),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m.valid = ~fifo_empty;
    assign m.data  = fifo_head[DW-1:0];
    assign m.last  = fifo_head[DW] & ~fifo_empty;

    assign done = done_zero_reg | final_fire;
    assign busy = (state_reg != IDLE) & ~final_fire;

`ifdef RAM_STREAM_READER_CNT_EN
    logic [AW:0] beat_cnt_reg;

    // Beats accepted in the current transfer; held after done until next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            beat_cnt_reg <= '0;
        end else if (fire) begin
            beat_cnt_reg <= beat_cnt_reg + (AW+1)'(1);
        end
    end

    assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader. A behavioural model derives, from
// the start request alone, the exact word sequence, when the stream must be
// valid, and when busy/done must be high; one negedge process compares every
// cycle. Directed transfers add literal checks on data, latency and done.
module tb_ram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  base;
    logic [6:0]  len;
    logic        busy;
    logic        done;
    logic [5:0]  ram_addr;
    logic [15:0] ram_rdata;
    logic        m_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
`ifdef RAM_STREAM_READER_CNT_EN
    logic [6:0]  beat_cnt;
`endif

    ram_stream_reader_if #(.DW(16)) sif ();

    assign sif.ready = m_ready;
    assign m_valid   = sif.valid;
    assign m_data    = sif.data;
    assign m_last    = sif.last;

    ram_stream_reader #(.AW(6), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
`ifdef RAM_STREAM_READER_CNT_EN
        .beat_cnt  (beat_cnt),
`endif
        .m         (sif)
    );

    // 64x16 RAM read port with registered read data.
    logic [15:0] mem [64];
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit check_en    = 1'b0;

    // Model state.
    bit          m_active     = 1'b0;
    bit          m_zero       = 1'b0;
    int          m_first_cyc  = 0;
    int          m_start_cyc  = 0;
    int          m_delivered  = 0;
    int          last_done_cyc = -1;
    logic [16:0] exp_q [$];
    logic [15:0] got_q [$];
    int          got_cyc [$];

    bit          exp_valid;
    bit          exp_done;
    bit          exp_busy;
    bit          last_beat;
    bit          was_active;
    logic [16:0] exp_front;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, then advance the model using the
    // inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        cyc++;
        was_active = m_active;
        exp_valid  = m_active && (exp_q.size() > 0) && (cyc >= m_first_cyc);
        exp_front  = exp_valid ? exp_q[0] : 17'h0;
        last_beat  = exp_valid && m_ready && exp_front[16];
        exp_done   = m_zero || last_beat;
        exp_busy   = m_active && !last_beat;
        if (done === 1'b1) last_done_cyc = cyc;

        if (check_en) begin
            chk("m_valid", 32'(m_valid), 32'(exp_valid));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_valid) begin
                chk("m_data", 32'(m_data), 32'(exp_front[15:0]));
                chk("m_last", 32'(m_last), 32'(exp_front[16]));
            end
`ifdef RAM_STREAM_READER_CNT_EN
            chk("beat_cnt", 32'(beat_cnt), 32'(m_delivered));
`endif
        end

        if (m_valid === 1'b1 && m_ready) begin
            got_q.push_back(m_data);
            got_cyc.push_back(cyc);
        end
        if (exp_valid && m_ready) begin
            void'(exp_q.pop_front());
            m_delivered++;
            if (last_beat) m_active = 1'b0;
        end

        m_zero = 1'b0;
        if (!rst_n) begin
            m_active    = 1'b0;
            m_delivered = 0;
            exp_q.delete();
        end else if (start && !was_active) begin
            m_delivered = 0;
            m_start_cyc = cyc;
            if (len == 7'd0) begin
                m_zero = 1'b1;
            end else begin
                for (int i = 0; i < int'(len); i++) begin
                    exp_q.push_back({1'(i == int'(len) - 1), mem[(int'(base) + i) % 64]});
                end
                m_first_cyc = cyc + 2;
                m_active    = 1'b1;
            end
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return (k % 3 == 0);
            2:       return ($urandom % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready;
    // 3: ready high with a second start injected mid-transfer.
    task automatic run_xfer(input int b, input int l, input int mode);
        int k;
        got_q.delete();
        got_cyc.delete();
        last_done_cyc = -1;
        base    = 6'(b);
        len     = 7'(l);
        start   = 1'b1;
        m_ready = ready_for(mode, 0);
        step();
        start = 1'b0;
        k = 1;
        while ((m_active || m_zero) && k < 400) begin
            m_ready = ready_for(mode, k);
            if (mode == 3 && k == 10) begin
                start = 1'b1;
                base  = 6'd0;
                len   = 7'd5;
            end
            step();
            start = 1'b0;
            k++;
        end
        if (k >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout waiting for transfer base=%0d len=%0d", b, l);
        end
        step();
        step();
        $display("xfer base=%0d len=%0d mode=%0d beats=%0d", b, l, mode, got_q.size());
    endtask

    initial begin
        int k;
        rst_n   = 1'b0;
        start   = 1'b0;
        base    = 6'd0;
        len     = 7'd0;
        m_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);

        repeat (3) step();
        rst_n    = 1'b1;
        check_en = 1'b1;
        chk("reset ram_addr", 32'(ram_addr), 32'd0);
        chk("reset m_data", 32'(m_data), 32'd0);
        chk("reset m_last", 32'(m_last), 32'd0);
        chk("reset m_valid", 32'(m_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
`ifdef RAM_STREAM_READER_CNT_EN
        chk("reset beat_cnt", 32'(beat_cnt), 32'd0);
`endif
        step();

        // Basic block: A000..A003, first beat 2 cycles after start, done with last.
        run_xfer(0, 4, 0);
        chk("t1 beats", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1 word", 32'(got_q[i]), 32'(16'hA000 + 16'(i)));
        chk("t1 latency", 32'(got_cyc[0] - m_start_cyc), 32'd2);
        chk("t1 back-to-back", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
        chk("t1 done cycle", 32'(last_done_cyc), 32'(got_cyc[3]));

        // Address wrap 62,63,0,1.
        run_xfer(62, 4, 0);
        chk("t2 beats", 32'(got_q.size()), 32'd4);
        chk("t2 w0", 32'(got_q[0]), 32'h0000A03E);
        chk("t2 w1", 32'(got_q[1]), 32'h0000A03F);
        chk("t2 w2", 32'(got_q[2]), 32'h0000A000);
        chk("t2 w3", 32'(got_q[3]), 32'h0000A001);

        // Stalling consumer.
        run_xfer(20, 5, 1);
        chk("t3 beats", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("t3 word", 32'(got_q[i]), 32'(16'hA014 + 16'(i)));

        // Zero-length request.
        run_xfer(7, 0, 0);
        chk("t4 beats", 32'(got_q.size()), 32'd0);
        chk("t4 done cycle", 32'(last_done_cyc - m_start_cyc), 32'd1);

        // Reset after two beats of an 8-word block.
        got_q.delete();
        got_cyc.delete();
        base    = 6'd0;
        len     = 7'd8;
        start   = 1'b1;
        m_ready = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (got_q.size() < 2 && k < 20) begin
            step();
            k++;
        end
        m_ready = 1'b0;
        rst_n   = 1'b0;
        step();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        chk("t5 beats before reset", 32'(got_q.size()), 32'd2);
        chk("t5 m_valid after reset", 32'(m_valid), 32'd0);
        chk("t5 busy after reset", 32'(busy), 32'd0);
        chk("t5 done after reset", 32'(done), 32'd0);
        repeat (4) step();
        run_xfer(5, 3, 0);
        chk("t5 beats after restart", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("t5 word", 32'(got_q[i]), 32'(16'hA005 + 16'(i)));

        // Full-depth block with wrap and an ignored start while busy.
        run_xfer(10, 64, 3);
        chk("t6 beats", 32'(got_q.size()), 32'd64);
        chk("t6 first", 32'(got_q[0]), 32'h0000A00A);
        chk("t6 addr63", 32'(got_q[53]), 32'h0000A03F);
        chk("t6 addr0", 32'(got_q[54]), 32'h0000A000);
        chk("t6 final", 32'(got_q[63]), 32'h0000A009);
`ifdef RAM_STREAM_READER_CNT_EN
        chk("t6 beat_cnt", 32'(beat_cnt), 32'd64);
`endif

        // Randomised blocks over random RAM contents and random back-pressure.
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        for (int t = 0; t < 10; t++) begin
            run_xfer(int'($urandom_range(0, 63)), int'($urandom_range(0, 64)), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
